// File: rtl/fir_pkg.sv
// Shared defaults, reset coefficient table and FSM state type for the FIR MAC scheduler.
package fir_pkg;

  localparam int unsigned N_DEF     = 5;
  localparam int unsigned DW_DEF    = 16;
  localparam int unsigned ACC_W_DEF = 32;
  localparam int unsigned N_MAX     = 8;
  localparam int unsigned ADDR_W    = 3;

  // Coefficients loaded by reset: coef[k] = k+1
  localparam int DEF_COEF [N_MAX] = '{1, 2, 3, 4, 5, 6, 7, 8};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/fir_mac_unit.sv
// Combinational multiply-accumulate step: full-width signed product, sign-extended into the accumulator.
module fir_mac_unit #(
  parameter int unsigned DW    = 16,
  parameter int unsigned ACC_W = 32
) (
  input  logic signed [DW-1:0]    sample,
  input  logic signed [DW-1:0]    coef,
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [ACC_W-1:0] sum_c
);

  logic signed [2*DW-1:0] prod;

  always_comb begin
    prod  = (2*DW)'(sample) * (2*DW)'(coef);
    sum_c = acc + ACC_W'(prod);
  end

endmodule

// File: rtl/fir_mac_scheduler.sv
// N-tap FIR filter sharing one multiplier across taps (IDLE -> MAC x N -> OUT).
// Define FIR_COEF_LOAD_EN to add the runtime coefficient write port.
module fir_mac_scheduler
  import fir_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_data,
  output logic                 busy
`ifdef FIR_COEF_LOAD_EN
  ,
  input  logic                 coef_wr_en,
  input  logic [ADDR_W-1:0]    coef_wr_addr,
  input  logic signed [DW-1:0] coef_wr_data
`endif
);

  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  state_t                  state_q, state_d;
  logic signed [DW-1:0]    hist [N];
  logic signed [DW-1:0]    coef [N];
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] sum_c;
  logic [IDX_W-1:0]        tap_q;
  logic                    accept;
  logic                    mac_last;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake decode
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    accept   = 1'b0;
    mac_last = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        if (tap_q == IDX_W'(N - 1)) begin
          mac_last = 1'b1;
          state_d  = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  fir_mac_unit #(
    .DW    (DW),
    .ACC_W (ACC_W)
  ) u_mac (
    .sample (hist[tap_q]),
    .coef   (coef[tap_q]),
    .acc    (acc_q),
    .sum_c  (sum_c)
  );

  // History, accumulator, tap counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < N; k++) hist[k] <= '0;
      acc_q     <= '0;
      tap_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
    end else begin
      busy <= (state_d != S_IDLE);
      if (accept) begin
        hist[0] <= in_data;
        for (int unsigned k = 1; k < N; k++) hist[k] <= hist[k-1];
        acc_q <= '0;
        tap_q <= '0;
      end
      if (state_q == S_MAC) begin
        acc_q <= sum_c;
        tap_q <= mac_last ? '0 : tap_q + IDX_W'(1);
      end
      // Result wraps to DW bits; held until the consumer takes it
      if (mac_last) begin
        out_valid <= 1'b1;
        out_data  <= DW'(sum_c);
      end else if (state_q == S_OUT && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Coefficient storage; runtime writes only land while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < N; k++) coef[k] <= DW'(DEF_COEF[k]);
    end
`ifdef FIR_COEF_LOAD_EN
    else if (coef_wr_en && state_q == S_IDLE && 32'(coef_wr_addr) < N) begin
      coef[IDX_W'(coef_wr_addr)] <= coef_wr_data;
    end
`endif
  end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Directed bench for fir_mac_scheduler (N=5, DW=16); coefficient-load scenario only with FIR_COEF_LOAD_EN.
module tb_fir_mac_scheduler;

  localparam int N  = 5;
  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;
  logic                 busy;
`ifdef FIR_COEF_LOAD_EN
  logic                 coef_wr_en;
  logic [2:0]           coef_wr_addr;
  logic signed [DW-1:0] coef_wr_data;
`endif

  int checks = 0;
  int errors = 0;

  fir_mac_scheduler #(.N(N), .DW(DW), .ACC_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef FIR_COEF_LOAD_EN
    ,
    .coef_wr_en   (coef_wr_en),
    .coef_wr_addr (coef_wr_addr),
    .coef_wr_data (coef_wr_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
`ifdef FIR_COEF_LOAD_EN
    coef_wr_en   = 1'b0;
    coef_wr_addr = '0;
    coef_wr_data = '0;
`endif
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Offer one sample and return just after the edge that accepts it
  task automatic drive_accept(input logic signed [DW-1:0] x);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    in_valid = 1'b1;
    in_data  = x;
    tick();
    in_valid = 1'b0;
  endtask

  // Cycles from the accept cycle until out_valid is seen (bounded)
  task automatic wait_out(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 30) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 16'sd99;
    out_ready = 1'b1;
`ifdef FIR_COEF_LOAD_EN
    coef_wr_en   = 1'b0;
    coef_wr_addr = '0;
    coef_wr_data = '0;
`endif
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_data !== 16'sd0) begin
      errors++;
      $display("FAIL reset: out_valid=%b busy=%b in_ready=%b out_data=%0d, need 0 0 1 0",
               out_valid, busy, in_ready, out_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_impulse();
    int xs [6];
    int ex [6];
    int cyc;
    xs = '{1, 0, 0, 0, 0, 0};
    ex = '{1, 2, 3, 4, 5, 0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive_accept(DW'(xs[i]));
      wait_out(cyc);
      checks++;
      if (out_valid !== 1'b1 || out_data !== DW'(ex[i])) begin
        errors++;
        $display("FAIL impulse[%0d]: out_valid=%b out_data=%0d, need 1 %0d", i, out_valid, out_data, ex[i]);
      end
      checks++;
      if (cyc !== N + 1) begin
        errors++;
        $display("FAIL impulse_latency[%0d]: %0d cycles, need %0d", i, cyc, N + 1);
      end
      tick();
    end
  endtask

  task automatic test_step();
    int ex [6];
    int cyc;
    ex = '{1, 3, 6, 10, 15, 15};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive_accept(16'sd1);
      wait_out(cyc);
      checks++;
      if (out_valid !== 1'b1 || out_data !== DW'(ex[i])) begin
        errors++;
        $display("FAIL step[%0d]: out_valid=%b out_data=%0d, need 1 %0d", i, out_valid, out_data, ex[i]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int acc_cyc [$];
    int cyc;
    do_reset();
    in_valid = 1'b1;
    in_data  = 16'sd1;
    for (int c = 0; c < 40 && acc_cyc.size() < 3; c++) begin
      if (in_ready) acc_cyc.push_back(c);
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (acc_cyc.size() !== 3) begin
      errors++;
      $display("FAIL b2b_accepts: %0d accepts, need 3", acc_cyc.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (acc_cyc[i] - acc_cyc[i-1] !== N + 2) begin
          errors++;
          $display("FAIL b2b_period[%0d]: %0d cycles, need %0d", i, acc_cyc[i] - acc_cyc[i-1], N + 2);
        end
      end
    end
    wait_out(cyc);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'sd6) begin
      errors++;
      $display("FAIL b2b_third: out_valid=%b out_data=%0d, need 1 6", out_valid, out_data);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int cyc;
    do_reset();
    out_ready = 1'b0;
    drive_accept(16'sd2);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_busy: busy=%b in_ready=%b, need 1 0", busy, in_ready);
    end
    in_valid = 1'b1;
    in_data  = 16'sd3;
    wait_out(cyc);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'sd2 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: out_valid=%b out_data=%0d in_ready=%b, need 1 2 0",
                 i, out_valid, out_data, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'sd2) begin
      errors++;
      $display("FAIL bp_still_held: out_valid=%b out_data=%0d, need 1 2", out_valid, out_data);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, need 0 1", out_valid, in_ready);
    end
    tick();
    in_valid = 1'b0;
    wait_out(cyc);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'sd7 || cyc !== N + 1) begin
      errors++;
      $display("FAIL bp_next: out_valid=%b out_data=%0d latency=%0d, need 1 7 %0d",
               out_valid, out_data, cyc, N + 1);
    end
    tick();
  endtask

  task automatic test_wrap();
    int ex [5];
    int cyc;
    ex = '{32767, 32765, -6, -10, 32753};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_accept(16'sd32767);
      wait_out(cyc);
      checks++;
      if (out_valid !== 1'b1 || out_data !== DW'(ex[i])) begin
        errors++;
        $display("FAIL wrap[%0d]: out_valid=%b out_data=%0d, need 1 %0d", i, out_valid, out_data, ex[i]);
      end
      tick();
    end
  endtask

  // Runs right after test_wrap so history and out_data are non-zero going in
  task automatic test_reset_mid_mac();
    int cyc;
    bit seen;
    drive_accept(16'sd7);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'sd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midmac_reset: busy=%b out_valid=%b out_data=%0d in_ready=%b, need 0 0 0 1",
               busy, out_valid, out_data, in_ready);
    end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seen |= out_valid;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL midmac_no_output: out_valid seen=%b, need 0", seen);
    end
    drive_accept(16'sd1);
    wait_out(cyc);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'sd1) begin
      errors++;
      $display("FAIL midmac_impulse: out_valid=%b out_data=%0d, need 1 1", out_valid, out_data);
    end
    tick();
  endtask

`ifdef FIR_COEF_LOAD_EN
  task automatic test_coef_load();
    int ex [5];
    int cyc;
    ex = '{1, 2, -1, 4, 5};
    do_reset();
    coef_wr_en   = 1'b1;
    coef_wr_addr = 3'd2;
    coef_wr_data = -16'sd1;
    tick();
    coef_wr_en = 1'b0;
    drive_accept(16'sd0);
    coef_wr_en   = 1'b1;
    coef_wr_addr = 3'd0;
    coef_wr_data = 16'sd9;
    tick();
    coef_wr_en = 1'b0;
    wait_out(cyc);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'sd0) begin
      errors++;
      $display("FAIL coef_zero: out_valid=%b out_data=%0d, need 1 0", out_valid, out_data);
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      drive_accept((i == 0) ? 16'sd1 : 16'sd0);
      wait_out(cyc);
      checks++;
      if (out_valid !== 1'b1 || out_data !== DW'(ex[i])) begin
        errors++;
        $display("FAIL coef_load[%0d]: out_valid=%b out_data=%0d, need 1 %0d", i, out_valid, out_data, ex[i]);
      end
      tick();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_impulse();
    test_step();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_reset_mid_mac();
`ifdef FIR_COEF_LOAD_EN
    test_coef_load();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
